// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP definitions for the transmit path.
//   - Header struct typedefs (Ethernet II, IPv4 without options, UDP).
//   - Frame size constants and the IPv4 ethertype.
//   - Transmit sequencer state enum and a pad-length helper.
package eth_pkg;

  localparam int unsigned ETH_HEADER_BYTES    = 42;
  localparam int unsigned ETH_MIN_FRAME_BYTES = 60;
  localparam logic [15:0] ETHERTYPE_IPV4      = 16'h0800;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
  } ethernet_header_t;

  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [7:0]  tos;
    logic [15:0] total_length;
    logic [15:0] identification;
    logic [2:0]  flags;
    logic [12:0] frag_offset;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] checksum;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } ipv4_header_t;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
    logic [15:0] checksum;
  } udp_header_t;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    PAD,
    DRAIN,
    GAP
  } tx_state_e;

  // Zero bytes needed after a payload of len bytes to reach the minimum frame.
  function automatic logic [11:0] calc_pad(input logic [11:0] len,
                                           input logic [11:0] min_payload);
    return (len < min_payload) ? (min_payload - len) : 12'd0;
  endfunction

endpackage

// File: rtl/eth_byte_mux.sv
// Output byte selector for the UDP transmit sequencer.
//   i_state      current sequencer state
//   i_hdr_data   packed header, byte n at [8n+7:8n]
//   i_idx        header byte index
//   i_s_tdata/i_s_tvalid  payload stream (passed straight through)
//   i_len, i_cnt, i_pad   declared length, beat/pad counter, pad amount
//   o_tdata/o_tvalid/o_tlast  byte-wide frame stream towards the MAC
module eth_byte_mux
  import eth_pkg::*;
#(
  parameter int unsigned HEADER_BYTES = ETH_HEADER_BYTES
) (
  input  tx_state_e                 i_state,
  input  logic [HEADER_BYTES*8-1:0] i_hdr_data,
  input  logic [5:0]                i_idx,
  input  logic [7:0]                i_s_tdata,
  input  logic                      i_s_tvalid,
  input  logic [11:0]               i_len,
  input  logic [11:0]               i_cnt,
  input  logic [11:0]               i_pad,
  output logic [7:0]                o_tdata,
  output logic                      o_tvalid,
  output logic                      o_tlast
);

  logic [8:0] w_bit_off;
  assign w_bit_off = {i_idx, 3'b000};

  always_comb begin
    o_tdata  = 8'h00;
    o_tvalid = 1'b0;
    o_tlast  = 1'b0;
    case (i_state)
      HEADER: begin
        o_tdata  = i_hdr_data[w_bit_off +: 8];
        o_tvalid = 1'b1;
        // Only reachable when the header alone meets the minimum frame size.
        o_tlast  = (i_idx == 6'(HEADER_BYTES - 1)) && (i_len == 12'd0) && (i_pad == 12'd0);
      end
      PAYLOAD: begin
        o_tdata  = i_s_tdata;
        o_tvalid = i_s_tvalid;
        o_tlast  = (i_cnt + 12'd1 == i_len) && (i_pad == 12'd0);
      end
      PAD: begin
        o_tvalid = 1'b1;
        o_tlast  = (i_cnt == 12'd1);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/eth_udp_tx_sequencer.sv
// Frame-level UDP transmit controller: header, payload, zero pad, then IFG.
//   clk, rstn                 clock, asynchronous active-low reset
//   req_*                     send request with payload length
//   hdr_payload_bytes/hdr_data  length to / packed header from the generator
//   s_axis_*                  payload stream in
//   m_axis_*                  byte-wide frame stream out
//   busy, err_len, frame_count  status
module eth_udp_tx_sequencer
  import eth_pkg::*;
#(
  parameter int unsigned HEADER_BYTES      = ETH_HEADER_BYTES,
  parameter int unsigned MIN_FRAME_BYTES   = ETH_MIN_FRAME_BYTES,
  parameter int unsigned MAX_PAYLOAD_BYTES = 1472,
  parameter int unsigned IFG_CYCLES        = 12
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [11:0]               req_payload_bytes,
  output logic [11:0]               hdr_payload_bytes,
  input  logic [HEADER_BYTES*8-1:0] hdr_data,
  input  logic [7:0]                s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  output logic [7:0]                m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      busy,
  output logic                      err_len,
  output logic [15:0]               frame_count
);

  localparam logic [11:0] MIN_PAYLOAD =
    (MIN_FRAME_BYTES > HEADER_BYTES) ? 12'(MIN_FRAME_BYTES - HEADER_BYTES) : 12'd0;
  localparam logic [5:0]  HDR_LAST = 6'(HEADER_BYTES - 1);
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

  tx_state_e   r_state;
  logic [11:0] r_len;
  logic [11:0] r_pad;
  logic [11:0] r_cnt;
  logic [5:0]  r_idx;
  logic [15:0] r_ifg;
  logic [15:0] r_frame_count;
  logic        r_err;
  logic        r_drain_pend;

  logic [7:0] w_m_tdata;
  logic       w_m_tvalid;
  logic       w_m_tlast;
  logic       w_m_hs;
  logic       w_s_hs;
  logic       w_len_hit;

  eth_byte_mux #(
    .HEADER_BYTES (HEADER_BYTES)
  ) u_byte_mux (
    .i_state    (r_state),
    .i_hdr_data (hdr_data),
    .i_idx      (r_idx),
    .i_s_tdata  (s_axis_tdata),
    .i_s_tvalid (s_axis_tvalid),
    .i_len      (r_len),
    .i_cnt      (r_cnt),
    .i_pad      (r_pad),
    .o_tdata    (w_m_tdata),
    .o_tvalid   (w_m_tvalid),
    .o_tlast    (w_m_tlast)
  );

  assign w_m_hs    = w_m_tvalid && m_axis_tready;
  assign w_s_hs    = s_axis_tvalid && m_axis_tready;
  assign w_len_hit = (r_cnt + 12'd1 == r_len);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_len         <= 12'd0;
      r_pad         <= 12'd0;
      r_cnt         <= 12'd0;
      r_idx         <= 6'd0;
      r_ifg         <= 16'd0;
      r_frame_count <= 16'd0;
      r_err         <= 1'b0;
      r_drain_pend  <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_m_hs && w_m_tlast) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (req_payload_bytes > 12'(MAX_PAYLOAD_BYTES)) begin
              r_err <= 1'b1;
            end else begin
              r_len        <= req_payload_bytes;
              r_pad        <= calc_pad(req_payload_bytes, MIN_PAYLOAD);
              r_idx        <= 6'd0;
              r_drain_pend <= 1'b0;
              r_state      <= HEADER;
            end
          end
        end
        HEADER: begin
          if (m_axis_tready) begin
            if (r_idx == HDR_LAST) begin
              if (r_len != 12'd0) begin
                r_cnt   <= 12'd0;
                r_state <= PAYLOAD;
              end else if (r_pad != 12'd0) begin
                r_cnt   <= r_pad;
                r_state <= PAD;
              end else begin
                r_ifg   <= 16'd0;
                r_state <= GAP;
              end
            end else begin
              r_idx <= r_idx + 6'd1;
            end
          end
        end
        PAYLOAD: begin
          if (w_s_hs) begin
            if (w_len_hit) begin
              // Declared length reached; anything still queued is overlong input.
              if (!s_axis_tlast) begin
                r_err        <= 1'b1;
                r_drain_pend <= 1'b1;
              end
              if (r_pad != 12'd0) begin
                r_cnt   <= r_pad;
                r_state <= PAD;
              end else if (!s_axis_tlast) begin
                r_state <= DRAIN;
              end else begin
                r_ifg   <= 16'd0;
                r_state <= GAP;
              end
            end else if (s_axis_tlast) begin
              // Short input: zero-fill the missing declared bytes plus normal pad.
              r_err   <= 1'b1;
              r_cnt   <= r_pad + (r_len - r_cnt - 12'd1);
              r_state <= PAD;
            end else begin
              r_cnt <= r_cnt + 12'd1;
            end
          end
        end
        PAD: begin
          if (m_axis_tready) begin
            r_cnt <= r_cnt - 12'd1;
            if (r_cnt == 12'd1) begin
              if (r_drain_pend) begin
                r_state <= DRAIN;
              end else begin
                r_ifg   <= 16'd0;
                r_state <= GAP;
              end
            end
          end
        end
        DRAIN: begin
          if (s_axis_tvalid && s_axis_tlast) begin
            r_drain_pend <= 1'b0;
            r_ifg        <= 16'd0;
            r_state      <= GAP;
          end
        end
        GAP: begin
          if (r_ifg == IFG_LAST) begin
            r_state <= IDLE;
          end else begin
            r_ifg <= r_ifg + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready         = (r_state == IDLE);
  assign busy              = (r_state != IDLE);
  assign s_axis_tready     = ((r_state == PAYLOAD) && m_axis_tready) || (r_state == DRAIN);
  assign hdr_payload_bytes = r_len;
  assign m_axis_tdata      = w_m_tdata;
  assign m_axis_tvalid     = w_m_tvalid;
  assign m_axis_tlast      = w_m_tlast;
  assign err_len           = r_err;
  assign frame_count       = r_frame_count;

endmodule

// File: tb/tb_eth_udp_tx_sequencer.sv
// Self-checking bench for eth_udp_tx_sequencer: randomized source/sink timing,
// frames predicted from the frame-building rules (header, payload, zero pad).
module tb_eth_udp_tx_sequencer;

  localparam int HB   = 42;
  localparam int MINF = 60;
  localparam int IFG  = 12;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [11:0]   req_payload_bytes = '0;
  logic [11:0]   hdr_payload_bytes;
  logic [HB*8-1:0] hdr_data = '0;
  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_last = 1'b0;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
  logic          busy;
  logic          err_len;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  eth_udp_tx_sequencer dut (
    .clk               (clk),
    .rstn              (rstn),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_payload_bytes (req_payload_bytes),
    .hdr_payload_bytes (hdr_payload_bytes),
    .hdr_data          (hdr_data),
    .s_axis_tdata      (s_data),
    .s_axis_tvalid     (s_valid),
    .s_axis_tready     (s_ready),
    .s_axis_tlast      (s_last),
    .m_axis_tdata      (m_data),
    .m_axis_tvalid     (m_valid),
    .m_axis_tready     (m_ready),
    .m_axis_tlast      (m_last)
    ,.busy             (busy),
    .err_len           (err_len),
    .frame_count       (frame_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Observation state, refreshed per frame.
  logic [7:0]  src_q[$];
  logic [7:0]  got_q[$];
  int          tlast_cnt, tlast_pos, err_cnt, drained, consumed, s_ready_hi;
  int          gap_cnt, gap_valid, exp_frames;
  int          ready_pct = 100;
  int          src_pct = 100;
  bit          after_last, prev_hold, s_hs, s_busy;
  logic [7:0]  prev_data;
  logic [11:0] cur_len, hdr_seen;

  task automatic clear_obs();
    got_q.delete();
    tlast_cnt = 0; tlast_pos = 0; err_cnt = 0; drained = 0; consumed = 0;
    s_ready_hi = 0; gap_cnt = 0; gap_valid = 0; after_last = 0;
  endtask

  // One clock: sample at the falling edge, drive 1 ns after the rising edge.
  task automatic step();
    bit hs_req;
    @(negedge clk);
    if (prev_hold) begin
      check_eq("hold_valid", 32'(m_valid), 32'd1);
      check_eq("hold_data", 32'(m_data), 32'(prev_data));
    end
    prev_hold = m_valid && !m_ready;
    prev_data = m_data;
    s_busy = busy;
    if (busy && hdr_payload_bytes != cur_len) hdr_seen = hdr_payload_bytes;
    if (after_last && busy) begin
      gap_cnt++;
      if (m_valid) gap_valid++;
    end
    if (s_ready) s_ready_hi++;
    if (err_len) err_cnt++;
    hs_req = req_valid && req_ready;
    if (m_valid && m_ready) begin
      got_q.push_back(m_data);
      if (m_last) begin
        tlast_cnt++;
        tlast_pos = got_q.size();
        after_last = 1'b1;
      end
    end
    s_hs = s_valid && s_ready;
    if (s_hs) begin
      consumed++;
      if (!m_valid) drained++;
      void'(src_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (hs_req) req_valid = 1'b0;
    m_ready = ($urandom_range(0, 99) < ready_pct);
    if (!(s_valid && !s_hs)) begin
      s_valid = (src_q.size() > 0) && ($urandom_range(0, 99) < src_pct);
    end
    if (src_q.size() > 0) begin
      s_data = src_q[0];
      s_last = (src_q.size() == 1);
    end else begin
      s_data = 8'h00;
      s_last = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
    check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
    check_eq({pfx, "_m_valid"}, 32'(m_valid), 32'd0);
    check_eq({pfx, "_m_last"}, 32'(m_last), 32'd0);
    check_eq({pfx, "_s_ready"}, 32'(s_ready), 32'd0);
    check_eq({pfx, "_err_len"}, 32'(err_len), 32'd0);
    check_eq({pfx, "_hdr_len"}, 32'(hdr_payload_bytes), 32'd0);
    check_eq({pfx, "_frame_count"}, 32'(frame_count), 32'd0);
  endtask

  // Loads a fresh header and source stream; returns the expected frame bytes.
  task automatic setup_frame(input int len, input int srclen, input bit incr,
                             output logic [7:0] exp_q[$]);
    exp_q.delete();
    src_q.delete();
    for (int i = 0; i < HB; i++) hdr_data[i*8 +: 8] = 8'($urandom);
    for (int i = 0; i < srclen; i++) src_q.push_back(incr ? 8'(i) : 8'($urandom));
    for (int i = 0; i < HB; i++) exp_q.push_back(hdr_data[i*8 +: 8]);
    for (int i = 0; i < len && i < srclen; i++) exp_q.push_back(src_q[i]);
    while (exp_q.size() < ((HB + len > MINF) ? HB + len : MINF)) exp_q.push_back(8'h00);
    clear_obs();
    cur_len = 12'(len);
    hdr_seen = 12'(len);
    req_payload_bytes = 12'(len);
    req_valid = 1'b1;
  endtask

  task automatic run_frame(input int len, input int srclen, input int rdy, input bit incr);
    logic [7:0] exp_q[$];
    int cycles;
    ready_pct = rdy;
    setup_frame(len, srclen, incr, exp_q);
    cycles = 0;
    while (!(got_q.size() >= exp_q.size() && !s_busy && src_q.size() == 0 && !req_valid)
           && cycles < 3000) begin
      step();
      cycles++;
    end
    check_eq("timeout", 32'(cycles < 3000), 32'd1);
    check_eq("frame_len", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check_eq($sformatf("byte[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    check_eq("tlast_cnt", 32'(tlast_cnt), 32'd1);
    check_eq("tlast_pos", 32'(tlast_pos), 32'(exp_q.size()));
    check_eq("err_len", 32'(err_cnt), 32'(srclen != len));
    check_eq("drained", 32'(drained), 32'((srclen > len) ? srclen - len : 0));
    check_eq("consumed", 32'(consumed), 32'(srclen));
    exp_frames++;
    check_eq("frame_count", 32'(frame_count), 32'(exp_frames));
    check_eq("hdr_len", 32'(hdr_seen), 32'(len));
    check_eq("gap_valid", 32'(gap_valid), 32'd0);
    if (srclen <= len) check_eq("gap_cycles", 32'(gap_cnt), 32'(IFG));
    if (len == 0) check_eq("s_ready_len0", 32'(s_ready_hi), 32'd0);
  endtask

  initial begin
    int len, srclen, mode;
    logic [11:0] last_len;
    exp_frames = 0;
    cur_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rstn = 1'b1;

    run_frame(100, 100, 100, 1'b1);
    run_frame(5, 5, 100, 1'b1);
    run_frame(0, 0, 100, 1'b1);
    run_frame(20, 8, 100, 1'b1);
    run_frame(10, 15, 100, 1'b1);
    run_frame(64, 64, 100, 1'b1);
    run_frame(64, 64, 50, 1'b1);

    // Oversized request: accepted, flagged, no frame started.
    last_len = hdr_payload_bytes;
    clear_obs();
    cur_len = last_len;
    req_payload_bytes = 12'd1500;
    req_valid = 1'b1;
    repeat (4) step();
    check_eq("reject_err", 32'(err_cnt), 32'd1);
    check_eq("reject_busy", 32'(s_busy), 32'd0);
    check_eq("reject_frames", 32'(frame_count), 32'(exp_frames));
    check_eq("reject_hdr_len", 32'(hdr_payload_bytes), 32'(last_len));

    // Reset in the middle of the header, then a clean frame.
    begin
      logic [7:0] exp_q[$];
      ready_pct = 100;
      setup_frame(64, 64, 1'b1, exp_q);
      repeat (20) step();
      rstn = 1'b0;
      #2;
      check_reset_state("midrst");
      src_q.delete();
      s_valid = 1'b0;
      s_last = 1'b0;
      prev_hold = 1'b0;
      exp_frames = 0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
    end
    run_frame(64, 64, 50, 1'b1);

    for (int n = 0; n < 6; n++) begin
      len = $urandom_range(0, 80);
      mode = $urandom_range(0, 2);
      srclen = len;
      if (mode == 1 && len >= 2) srclen = $urandom_range(1, len - 1);
      if (mode == 2 && len >= 1) srclen = len + $urandom_range(1, 6);
      src_pct = $urandom_range(50, 100);
      run_frame(len, srclen, $urandom_range(30, 100), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
